// File: rtl/popcount28_unary_gen.sv
// popcount28_unary_gen
// Regenerates a 28-bit vector whose popcount equals a requested 5-bit count,
// saturated at 28. Two patterns are supported: thermometer (ones first) and
// spread (ones evenly distributed via a Bresenham-style accumulator).
// The vector is streamed bit-serially (position 0 first) while it is being
// assembled into a parallel word, which is then held until consumed.
//
// Cycle plan for an accept on edge T:
//   RUN is entered at T. Edges T+1..T+28 register positions 0..27 onto the
//   serial outputs. Edge T+29 is a drain step that drops ser_valid and moves
//   to DONE, so out_valid is seen after edge T+29. With out_ready high, DONE
//   lasts one cycle and in_ready is back after edge T+30.
module popcount28_unary_gen #(
  parameter int N  = 28,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] input_a,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          ser_valid,
  output logic          ser_bit,
  output logic [CW-1:0] ser_idx,
  output logic [N-1:0]  popcount28_unary_gen_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest representable count; also the position value that marks the drain step.
  localparam logic [CW-1:0] K_MAX    = CW'(N);
  localparam logic [CW:0]   ACC_WRAP = (CW + 1)'(N);
  localparam logic [CW-1:0] POS_ONE  = CW'(1);

  state_t        state_r;
  state_t        state_next_s;

  logic [CW-1:0] k_r;
  logic          mode_r;
  logic          sat_r;
  logic [CW:0]   acc_r;
  logic [CW-1:0] pos_r;
  logic [N-1:0]  vec_r;
  logic          ser_valid_r;
  logic          ser_bit_r;
  logic [CW-1:0] ser_idx_r;

  logic [CW-1:0] k_in_s;
  logic          sat_in_s;
  logic [CW:0]   sum_s;
  logic          hit_s;
  logic [CW:0]   acc_next_s;
  logic          bit_s;
  logic          drain_s;

  // Request clamping, accumulator step and bit selection for the current position.
  always_comb begin
    k_in_s     = input_a;
    sat_in_s   = 1'b0;
    sum_s      = acc_r + {1'b0, k_r};
    hit_s      = 1'b0;
    acc_next_s = sum_s;
    bit_s      = 1'b0;
    drain_s    = (pos_r == K_MAX);

    if (input_a > K_MAX) begin
      k_in_s   = K_MAX;
      sat_in_s = 1'b1;
    end else begin
      k_in_s   = input_a;
      sat_in_s = 1'b0;
    end

    // acc stays below 28 and k is at most 28, so one subtraction suffices.
    if (sum_s >= ACC_WRAP) begin
      hit_s      = 1'b1;
      acc_next_s = sum_s - ACC_WRAP;
    end else begin
      hit_s      = 1'b0;
      acc_next_s = sum_s;
    end

    if (mode_r) begin
      bit_s = hit_s;
    end else begin
      bit_s = (pos_r < k_r);
    end
  end

  // Next-state decode for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (drain_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request latch, serial emission and parallel vector assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_r         <= '0;
      mode_r      <= 1'b0;
      sat_r       <= 1'b0;
      acc_r       <= '0;
      pos_r       <= '0;
      vec_r       <= '0;
      ser_valid_r <= 1'b0;
      ser_bit_r   <= 1'b0;
      ser_idx_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          ser_valid_r <= 1'b0;
          ser_bit_r   <= 1'b0;
          ser_idx_r   <= '0;
          if (in_valid) begin
            k_r    <= k_in_s;
            mode_r <= mode;
            sat_r  <= sat_in_s;
            acc_r  <= '0;
            pos_r  <= '0;
            vec_r  <= '0;
          end
        end
        RUN: begin
          if (drain_s) begin
            ser_valid_r <= 1'b0;
            ser_bit_r   <= 1'b0;
            ser_idx_r   <= '0;
          end else begin
            ser_valid_r  <= 1'b1;
            ser_bit_r    <= bit_s;
            ser_idx_r    <= pos_r;
            vec_r[pos_r] <= bit_s;
            pos_r        <= pos_r + POS_ONE;
            if (mode_r) begin
              acc_r <= acc_next_s;
            end
          end
        end
        DONE: begin
          ser_valid_r <= 1'b0;
          ser_bit_r   <= 1'b0;
          ser_idx_r   <= '0;
        end
        default: begin
          ser_valid_r <= 1'b0;
          ser_bit_r   <= 1'b0;
          ser_idx_r   <= '0;
        end
      endcase
    end
  end

  assign in_ready                 = (state_r == IDLE);
  assign out_valid                = (state_r == DONE);
  assign ser_valid                = ser_valid_r;
  assign ser_bit                  = ser_bit_r;
  assign ser_idx                  = ser_idx_r;
  assign popcount28_unary_gen_out = vec_r;
  assign sat                      = sat_r;

endmodule

// File: tb/tb_popcount28_unary_gen.sv
// Directed self-checking bench for popcount28_unary_gen.
module tb_popcount28_unary_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  input_a = 5'd0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        ser_valid;
  logic        ser_bit;
  logic [4:0]  ser_idx;
  logic [27:0] vec;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sat;

  int n_chk  = 0;
  int n_pass = 0;

  popcount28_unary_gen #(.N(28), .CW(5)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .input_a                  (input_a),
    .mode                     (mode),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .ser_valid                (ser_valid),
    .ser_bit                  (ser_bit),
    .ser_idx                  (ser_idx),
    .popcount28_unary_gen_out (vec),
    .out_valid                (out_valid),
    .out_ready                (out_ready),
    .sat                      (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference vector: position i holds a one when floor((i+1)k/28) steps past floor(ik/28).
  function automatic logic [27:0] model(input int a, input int m);
    int k;
    logic [27:0] v;
    k = (a > 28) ? 28 : a;
    v = 28'd0;
    for (int i = 0; i < 28; i++) begin
      if (m == 0) v[i] = (i < k);
      else        v[i] = (((i + 1) * k) / 28) != ((i * k) / 28);
    end
    return v;
  endfunction

  // Issue one request from a negedge; returns at the negedge where out_valid is first seen.
  task automatic run_req(input logic [4:0] a, input logic m, input int pulse_at,
                         output logic [27:0] ser_v, output int lat, output bit idx_ok);
    int cnt;
    input_a  = a;
    mode     = m;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    ser_v  = 28'd0;
    lat    = -1;
    idx_ok = 1'b1;
    cnt    = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == pulse_at) begin
        in_valid = 1'b1;
        input_a  = 5'd20;
        mode     = ~m;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (ser_valid) begin
        if (ser_idx != cnt[4:0]) idx_ok = 1'b0;
        ser_v[ser_idx] = ser_bit;
        cnt++;
      end
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    in_valid = 1'b0;
    if (cnt != 28) idx_ok = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [4:0] a, input logic m,
                          input logic [27:0] exp_v, input logic exp_sat);
    logic [27:0] sv;
    int lat;
    bit ok;
    out_ready = 1'b1;
    run_req(a, m, 0, sv, lat, ok);
    chk({tag, " vec"}, {4'd0, vec}, {4'd0, exp_v});
    chk({tag, " serial"}, {4'd0, sv}, {4'd0, exp_v});
    chk({tag, " sat"}, {31'd0, sat}, {31'd0, exp_sat});
    chk({tag, " idx"}, {31'd0, ok}, 32'd1);
    chk({tag, " lat"}, lat, 32'd29);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done1 out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " done1 in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [27:0] sv, held;
    int lat;
    bit ok, stable, seen;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst ser_valid", {31'd0, ser_valid}, 32'd0);
    chk("rst ser_bit", {31'd0, ser_bit}, 32'd0);
    chk("rst ser_idx", {27'd0, ser_idx}, 32'd0);
    chk("rst vec", {4'd0, vec}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst sat", {31'd0, sat}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    directed("therm k0",  5'd0,  1'b0, 28'h0000000, 1'b0);
    directed("therm k5",  5'd5,  1'b0, 28'h000001F, 1'b0);
    directed("spread k7", 5'd7,  1'b1, 28'h8888888, 1'b0);
    directed("spread k14", 5'd14, 1'b1, 28'hAAAAAAA, 1'b0);
    directed("therm k28", 5'd28, 1'b0, 28'hFFFFFFF, 1'b0);
    directed("spread a31", 5'd31, 1'b1, 28'hFFFFFFF, 1'b1);
    directed("spread k0", 5'd0,  1'b1, 28'h0000000, 1'b0);

    // Exhaustive popcount sweep
    out_ready = 1'b1;
    for (int a = 0; a < 32; a++) begin
      for (int m = 0; m < 2; m++) begin
        run_req(a[4:0], m[0], 0, sv, lat, ok);
        chk($sformatf("sweep a=%0d m=%0d vec", a, m), {4'd0, vec}, {4'd0, model(a, m)});
        chk($sformatf("sweep a=%0d m=%0d pop", a, m), $countones(vec), (a > 28) ? 28 : a);
        chk($sformatf("sweep a=%0d m=%0d lat", a, m), lat, 32'd29);
        chk($sformatf("sweep a=%0d m=%0d sat", a, m), {31'd0, sat}, {31'd0, (a > 28)});
        @(posedge clk);
        @(negedge clk);
      end
    end

    // Backpressure with a busy-time request pulse during RUN
    out_ready = 1'b0;
    run_req(5'd9, 1'b0, 10, sv, lat, ok);
    chk("bp vec", {4'd0, vec}, 32'h00001FF);
    chk("bp serial", {4'd0, sv}, 32'h00001FF);
    chk("bp lat", lat, 32'd29);
    held   = vec;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 4);
      input_a  = 5'd3;
      @(posedge clk);
      @(negedge clk);
      if (vec !== held || in_ready !== 1'b0 || out_valid !== 1'b1 || ser_valid !== 1'b0) stable = 1'b0;
    end
    chk("bp stable", {31'd0, stable}, 32'd1);
    // out_ready together with in_valid in DONE: consume only
    out_ready = 1'b1;
    in_valid  = 1'b1;
    input_a   = 5'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp release out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp no accept in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp no accept ser_valid", {31'd0, ser_valid}, 32'd0);
    chk("bp vec kept", {4'd0, vec}, 32'h00001FF);

    // Reset abort at ser_idx 12
    input_a  = 5'd30;
    mode     = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (ser_valid && ser_idx == 5'd12) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort reached idx12", {31'd0, seen}, 32'd1);
    chk("abort sat before", {31'd0, sat}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort ser_valid", {31'd0, ser_valid}, 32'd0);
    chk("abort ser_bit", {31'd0, ser_bit}, 32'd0);
    chk("abort ser_idx", {27'd0, ser_idx}, 32'd0);
    chk("abort vec", {4'd0, vec}, 32'd0);
    chk("abort out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort sat", {31'd0, sat}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (out_valid || ser_valid) seen = 1'b1;
    end
    chk("abort no out_valid", {31'd0, seen}, 32'd0);
    directed("after abort k21", 5'd21, 1'b0, 28'h01FFFFF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
